barrel_shift_seq: RTL and testbench
===================================

# barrel_shift_seq

Iterative ARM operand-2 shifter that sits directly upstream of the ALU. It takes a register operand (Rm), a register-specified shift amount (Rs[7:0]) and a shift type, and produces the ALU `B` operand and `Shift_Carry_Out`. It shifts one bit per clock under a start/done handshake, which trades latency for area in the multi-cycle ARM model.

## Interface
- No parameters. Width is fixed at 32 bits (ARM word). Bit vectors are indexed [32:1], with [32] as MSB.
- Clk  in  1  system clock; all state updates on rising edge
- Rst  in  1  synchronous, active-high reset
- Start  in  1  request; sampled only when Busy=0
- Shift_Data  in  32  operand to shift (Rm)
- Shift_Num  in  8  shift amount, Rs[7:0], range 0..255
- SHIFT_OP  in  2  type: 00 LSL, 01 LSR, 10 ASR, 11 ROR
- CF  in  1  current carry flag, used when Shift_Num=0
- Busy  out  1  operation in progress
- Done  out  1  one-cycle pulse; Shift_Out/Shift_Carry_Out valid from this cycle
- Shift_Out  out  32  shifted result; feeds ALU B
- Shift_Carry_Out  out  1  shifter carry; feeds ALU Shift_Carry_Out

## Operation
- FSM states:
  - IDLE. Busy=0.
  - SHIFT. Busy=1.
- Accept edge (IDLE with Start=1):
  - Load the working register W=Shift_Data and the working carry C=CF.
  - Latch the type and load the step counter N, then go to SHIFT.
  - Inputs are ignored after the accept edge.
- N on accept:
  - Shift_Num=0: N=0, C=CF (all types).
  - LSL/LSR: N=min(Shift_Num,33).
  - ASR: N=min(Shift_Num,32).
  - ROR, Shift_Num[5:1]≠0: N=Shift_Num[5:1].
  - ROR, Shift_Num≠0 and Shift_Num[5:1]=0: N=0 and C=Shift_Data[32].
- Each edge in SHIFT with N>0 performs one 1-bit step and decrements N:
  - LSL: C=W[32]; W={W[31:1],0}.
  - LSR: C=W[1]; W={0,W[32:2]}.
  - ASR: C=W[1]; W={W[32],W[32:2]}.
  - ROR: C=W[1]; W={W[1],W[32:2]}.
- Edge in SHIFT with N=0 (completion):
  - Shift_Out←W, Shift_Carry_Out←C.
  - Done=1 for this one cycle; return to IDLE.
- The clamping yields the ARM amount ≥32 semantics:
  - LSL by 32: result 0, carry=orig[1].
  - LSR by 32: result 0, carry=orig[32].
  - LSL/LSR by more than 32: result 0, carry 0.
  - ASR by 32 or more: all bits and carry = sign.
- Shift_Out and Shift_Carry_Out hold the last completed result and change only at completion. W and C are internal.
- Start while Busy=1 is ignored. There is no queueing.
- Start in the Done cycle is accepted, since the FSM is already in IDLE.

## Timing
- Reset values: state IDLE, Busy=0, Done=0, Shift_Out=32'h0, Shift_Carry_Out=0, N=0, W=0, C=0.
- Rst asserted mid-operation aborts on that edge. No Done is produced and outputs return to reset values. Rst has priority over Start.
- Latency: if the accept edge is edge k, the completion edge is k+N+1. Done is high during the cycle after edge k+N+1.
- Minimum latency is 1 cycle (N=0); maximum is 34 cycles (LSL/LSR ≥33).
- Busy is high from the cycle after accept until the completion edge, inclusive of N+1 cycles.
- Busy and Done are never high in the same cycle.
- Back-to-back throughput: one operation per N+2 cycles.

## Test plan
- LSL, Shift_Data=32'h365aacf9, Shift_Num=4, CF=0 -> Shift_Out=32'h65aacf90, Shift_Carry_Out=1, Done 5 cycles after the accept edge, Busy high 5 cycles.
- LSR, Shift_Num=0, Shift_Data=32'hac963a55, CF=1 -> Shift_Out=32'hac963a55, carry=1, Done 1 cycle after accept.
- ASR, Shift_Data=32'hac963a55, Shift_Num=40 -> Shift_Out=32'hffffffff, carry=1, Done after 33 cycles.
- ROR, Shift_Data=32'hac963a55:
  - Shift_Num=8 -> Shift_Out=32'h55ac963a, carry=0.
  - Shift_Num=32 -> Shift_Out=32'hac963a55, carry=1, latency 1.
- LSR by 32 and LSL by 33, Shift_Data=32'hac963a55:
  - LSR 32 -> Shift_Out=0, carry=1.
  - LSL 33 -> Shift_Out=0, carry=0, latency 34.
- Control:
  - Start pulsed while Busy -> ignored; the first result is unchanged.
  - Rst asserted 3 cycles into LSL-by-20 -> no Done; Shift_Out=0, Busy=0 next cycle.
  - Start in the Done cycle -> accepted.

Source files
------------

// File: rtl/barrel_shift_seq.sv
// barrel_shift_seq
//
// Iterative ARM operand-2 shifter feeding the ALU B input. One operand is
// accepted under a Start/Busy handshake and shifted one bit per clock, so a
// single 1-bit shift stage replaces a full 32-bit barrel network.
//
// Ports:
//   Clk             in   system clock, all state changes on the rising edge
//   Rst             in   synchronous active-high reset, wins over Start
//   Start           in   request, only looked at while Busy is low
//   Shift_Data      in   32-bit operand to shift (Rm)
//   Shift_Num       in   8-bit shift amount (Rs[7:0]), 0..255
//   SHIFT_OP        in   00 LSL, 01 LSR, 10 ASR, 11 ROR
//   CF              in   current carry flag, passed through for amount 0
//   Busy            out  operation in progress
//   Done            out  one-cycle pulse, result valid from this cycle on
//   Shift_Out       out  shifted result (ALU B operand)
//   Shift_Carry_Out out  shifter carry out
//
// Bit numbering note: the ARM reference numbers bits [32:1]; here the same
// bits are [31:0], so reference bit [32] is [31] and reference bit [1] is [0].

module barrel_shift_seq (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic [31:0] Shift_Data,
    input  logic [7:0]  Shift_Num,
    input  logic [1:0]  SHIFT_OP,
    input  logic        CF,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Shift_Out,
    output logic        Shift_Carry_Out
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    localparam logic [1:0] OP_LSL = 2'b00;
    localparam logic [1:0] OP_LSR = 2'b01;
    localparam logic [1:0] OP_ASR = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    logic [0:0]  state;
    logic [1:0]  op;
    logic [5:0]  count;
    logic [31:0] work;
    logic        work_carry;

    logic [5:0]  load_count;
    logic        load_carry;
    logic [31:0] step_work;
    logic        step_carry;

    assign Busy = (state == SHIFT);

    // Number of 1-bit steps for the accepted operation. Clamping LSL/LSR at
    // 33 and ASR at 32 lets the plain 1-bit stepping produce the ARM results
    // for amounts of 32 and above. ROR only uses the amount modulo 32; a
    // nonzero multiple of 32 rotates nothing but still reports bit 31 as the
    // carry, so that carry is preloaded here instead of coming from a step.
    always_comb begin
        load_count = 6'd0;
        load_carry = CF;
        if (Shift_Num != 8'd0) begin
            case (SHIFT_OP)
                OP_LSL, OP_LSR: load_count = (Shift_Num > 8'd33) ? 6'd33 : Shift_Num[5:0];
                OP_ASR:         load_count = (Shift_Num > 8'd32) ? 6'd32 : Shift_Num[5:0];
                default: begin
                    load_count = {1'b0, Shift_Num[4:0]};
                    if (Shift_Num[4:0] == 5'd0) begin
                        load_carry = Shift_Data[31];
                    end
                end
            endcase
        end
    end

    // One bit of shift on the working register; the carry is always the
    // bit that falls off the end.
    always_comb begin
        step_work  = work;
        step_carry = work_carry;
        case (op)
            OP_LSL: begin
                step_carry = work[31];
                step_work  = {work[30:0], 1'b0};
            end
            OP_LSR: begin
                step_carry = work[0];
                step_work  = {1'b0, work[31:1]};
            end
            OP_ASR: begin
                step_carry = work[0];
                step_work  = {work[31], work[31:1]};
            end
            default: begin
                step_carry = work[0];
                step_work  = {work[0], work[31:1]};
            end
        endcase
    end

    // Control and datapath. The visible outputs only change on the
    // completion edge, so the ALU always sees the last finished result.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state           <= IDLE;
            op              <= OP_LSL;
            count           <= 6'd0;
            work            <= 32'h0;
            work_carry      <= 1'b0;
            Done            <= 1'b0;
            Shift_Out       <= 32'h0;
            Shift_Carry_Out <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        op         <= SHIFT_OP;
                        count      <= load_count;
                        work       <= Shift_Data;
                        work_carry <= load_carry;
                        state      <= SHIFT;
                    end
                end
                default: begin
                    if (count != 6'd0) begin
                        work       <= step_work;
                        work_carry <= step_carry;
                        count      <= count - 6'd1;
                    end else begin
                        Shift_Out       <= work;
                        Shift_Carry_Out <= work_carry;
                        Done            <= 1'b1;
                        state           <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_barrel_shift_seq.sv
// tb_barrel_shift_seq
//
// Directed bench for barrel_shift_seq. Inputs are driven and outputs are
// sampled on the falling clock edge; every expected value is hand-computed.

module tb_barrel_shift_seq;

    localparam logic [1:0] OP_LSL = 2'b00;
    localparam logic [1:0] OP_LSR = 2'b01;
    localparam logic [1:0] OP_ASR = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Start;
    logic [31:0] Shift_Data;
    logic [7:0]  Shift_Num;
    logic [1:0]  SHIFT_OP;
    logic        CF;
    logic        Busy;
    logic        Done;
    logic [31:0] Shift_Out;
    logic        Shift_Carry_Out;

    int compare_count = 0;
    int fail_count    = 0;

    barrel_shift_seq dut (
        .Clk             (Clk),
        .Rst             (Rst),
        .Start           (Start),
        .Shift_Data      (Shift_Data),
        .Shift_Num       (Shift_Num),
        .SHIFT_OP        (SHIFT_OP),
        .CF              (CF),
        .Busy            (Busy),
        .Done            (Done),
        .Shift_Out       (Shift_Out),
        .Shift_Carry_Out (Shift_Carry_Out)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compare_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Called on a falling edge; the next rising edge is the accept edge.
    // Afterwards the inputs are scrambled, since the DUT must ignore them.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] data,
                                 input logic [7:0] num, input logic c);
        SHIFT_OP   = op;
        Shift_Data = data;
        Shift_Num  = num;
        CF         = c;
        Start      = 1'b1;
        @(negedge Clk);
        Start      = 1'b0;
        Shift_Data = ~data;
        Shift_Num  = 8'd1;
        CF         = ~c;
    endtask

    // Starts on the falling edge just after the accept edge and returns on
    // the falling edge of the Done cycle. latency counts rising edges from
    // accept to completion. pulse_at raises Start for one cycle mid-run.
    task automatic waitDone(input int pulse_at, output int latency,
                            output int busy_cycles, output logic timed_out);
        int cycles;
        cycles      = 1;
        busy_cycles = 0;
        while (!Done && cycles <= 40) begin
            if (Busy) busy_cycles++;
            Start = (cycles == pulse_at);
            @(negedge Clk);
            cycles++;
        end
        Start     = 1'b0;
        timed_out = !Done;
        latency   = cycles - 1;
    endtask

    task automatic runOp(input string tag, input logic [1:0] op, input logic [31:0] data,
                         input logic [7:0] num, input logic c, input logic [31:0] exp_out,
                         input logic exp_carry, input int exp_latency);
        int   lat;
        int   busy_n;
        logic to;
        applyStimulus(op, data, num, c);
        waitDone(0, lat, busy_n, to);
        checkOutput({tag, " timeout"}, 32'(to), 32'd0);
        checkOutput({tag, " result"}, Shift_Out, exp_out);
        checkOutput({tag, " carry"}, 32'(Shift_Carry_Out), 32'(exp_carry));
        checkOutput({tag, " latency"}, 32'(lat), 32'(exp_latency));
        checkOutput({tag, " busy cycles"}, 32'(busy_n), 32'(exp_latency));
        checkOutput({tag, " busy in done cycle"}, 32'(Busy), 32'd0);
        @(negedge Clk);
        checkOutput({tag, " done single pulse"}, 32'(Done), 32'd0);
    endtask

    initial begin
        int   lat;
        int   busy_n;
        int   done_seen;
        logic to;

        Rst        = 1'b1;
        Start      = 1'b0;
        Shift_Data = 32'h0;
        Shift_Num  = 8'd0;
        SHIFT_OP   = OP_LSL;
        CF         = 1'b0;
        repeat (3) @(negedge Clk);
        $display("[TB] reset state");
        checkOutput("reset busy", 32'(Busy), 32'd0);
        checkOutput("reset done", 32'(Done), 32'd0);
        checkOutput("reset result", Shift_Out, 32'h0);
        checkOutput("reset carry", 32'(Shift_Carry_Out), 32'd0);
        Rst = 1'b0;
        @(negedge Clk);

        $display("[TB] single operations");
        runOp("LSL4",  OP_LSL, 32'h365aacf9, 8'd4,  1'b0, 32'h65aacf90, 1'b1, 5);
        runOp("LSR0",  OP_LSR, 32'hac963a55, 8'd0,  1'b1, 32'hac963a55, 1'b1, 1);
        runOp("ASR40", OP_ASR, 32'hac963a55, 8'd40, 1'b0, 32'hffffffff, 1'b1, 33);
        runOp("ROR32", OP_ROR, 32'hac963a55, 8'd32, 1'b0, 32'hac963a55, 1'b1, 1);
        runOp("LSR32", OP_LSR, 32'hac963a55, 8'd32, 1'b0, 32'h00000000, 1'b1, 33);
        runOp("LSL33", OP_LSL, 32'hac963a55, 8'd33, 1'b1, 32'h00000000, 1'b0, 34);
        runOp("ROR8",  OP_ROR, 32'hac963a55, 8'd8,  1'b1, 32'h55ac963a, 1'b0, 9);

        $display("[TB] reset mid-operation");
        applyStimulus(OP_LSL, 32'h365aacf9, 8'd20, 1'b1);
        repeat (2) @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        checkOutput("abort busy", 32'(Busy), 32'd0);
        checkOutput("abort done", 32'(Done), 32'd0);
        checkOutput("abort result", Shift_Out, 32'h0);
        checkOutput("abort carry", 32'(Shift_Carry_Out), 32'd0);
        done_seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge Clk);
            if (Done) done_seen++;
        end
        checkOutput("abort no done", 32'(done_seen), 32'd0);

        $display("[TB] start while busy");
        applyStimulus(OP_LSL, 32'h365aacf9, 8'd4, 1'b0);
        SHIFT_OP   = OP_LSR;
        Shift_Data = 32'hffffffff;
        waitDone(2, lat, busy_n, to);
        checkOutput("busy-start timeout", 32'(to), 32'd0);
        checkOutput("busy-start result", Shift_Out, 32'h65aacf90);
        checkOutput("busy-start carry", 32'(Shift_Carry_Out), 32'd1);
        checkOutput("busy-start latency", 32'(lat), 32'd5);
        @(negedge Clk);
        checkOutput("busy-start not queued", 32'(Busy), 32'd0);

        $display("[TB] start in done cycle");
        applyStimulus(OP_LSL, 32'h365aacf9, 8'd4, 1'b0);
        waitDone(0, lat, busy_n, to);
        checkOutput("chain first done", 32'(Done), 32'd1);
        checkOutput("chain first result", Shift_Out, 32'h65aacf90);
        applyStimulus(OP_LSR, 32'h365aacf9, 8'd4, 1'b0);
        checkOutput("chain accepted", 32'(Busy), 32'd1);
        waitDone(0, lat, busy_n, to);
        checkOutput("chain second timeout", 32'(to), 32'd0);
        checkOutput("chain second result", Shift_Out, 32'h0365aacf);
        checkOutput("chain second carry", 32'(Shift_Carry_Out), 32'd1);
        checkOutput("chain second latency", 32'(lat), 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
        $finish;
    end

endmodule
